// File: rtl/seven_segment_display_mux.sv
// Multiplexed N-digit hex seven-segment display engine.
// Owns cursor, decimal points, blink and leading-zero blanking.
module seven_segment_display_mux #(
    parameter int NUM_DIGITS      = 8,
    parameter int SCAN_DIVISIONS  = 18,
    parameter int BLINK_DIVISIONS = 24,
    parameter int CW              = $clog2(NUM_DIGITS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    leftPulse,
    input  logic                    rightPulse,
    input  logic                    togglePulse,
    input  logic                    blinkEnable,
    input  logic                    suppressZeros,
    output logic [7:0]              segmentEnableN,
    output logic [NUM_DIGITS-1:0]   digitEnableN,
    output logic [CW-1:0]           cursor,
    output logic [NUM_DIGITS-1:0]   pointEnable
);

    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    logic [SCAN_DIVISIONS-1:0]  prescaler;
    logic [CW-1:0]              scanIndex;
    logic [BLINK_DIVISIONS-1:0] blinkCount;
    logic [3:0]                 nibble;
    logic [7:0]                 pattern;
    logic [NUM_DIGITS-1:0]      leading;
    logic [NUM_DIGITS-1:0]      select;
    logic                       run;

    // Free-running prescaler and blink counter; digit slot advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            blinkCount <= '0;
            scanIndex  <= '0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            blinkCount <= blinkCount + 1'b1;
            if (&prescaler) begin
                if (scanIndex == LAST)
                    scanIndex <= '0;
                else
                    scanIndex <= scanIndex + 1'b1;
            end
        end
    end

    // Cursor movement and point toggle (toggle uses pre-move cursor).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cursor      <= '0;
            pointEnable <= '0;
        end else begin
            if (leftPulse && !rightPulse) begin
                if (cursor == LAST)
                    cursor <= '0;
                else
                    cursor <= cursor + 1'b1;
            end else if (rightPulse && !leftPulse) begin
                if (cursor == '0)
                    cursor <= LAST;
                else
                    cursor <= cursor - 1'b1;
            end
            if (togglePulse)
                pointEnable[cursor] <= ~pointEnable[cursor];
        end
    end

    // Leading-zero run: digit i and everything above is blank-able.
    always_comb begin
        run     = 1'b1;
        leading = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run & (data[4*i +: 4] == 4'h0) & ~pointEnable[i];
            leading[i] = run;
        end
    end

    // Decode the scanned nibble, then apply blink and blanking.
    always_comb begin
        nibble = data[{scanIndex, 2'b00} +: 4];
        case (nibble)
            4'h0:    pattern = 8'hC0;
            4'h1:    pattern = 8'hF9;
            4'h2:    pattern = 8'hA4;
            4'h3:    pattern = 8'hB0;
            4'h4:    pattern = 8'h99;
            4'h5:    pattern = 8'h92;
            4'h6:    pattern = 8'h82;
            4'h7:    pattern = 8'hF8;
            4'h8:    pattern = 8'h80;
            4'h9:    pattern = 8'h90;
            4'hA:    pattern = 8'h88;
            4'hB:    pattern = 8'h83;
            4'hC:    pattern = 8'hC6;
            4'hD:    pattern = 8'hA1;
            4'hE:    pattern = 8'h86;
            default: pattern = 8'h8E;
        endcase
        pattern[7] = ~pointEnable[scanIndex];
        if (blinkEnable && blinkCount[BLINK_DIVISIONS-1] &&
            scanIndex == cursor)
            pattern[6:0] = 7'h7F;
        if (suppressZeros && scanIndex != '0 && leading[scanIndex])
            pattern = 8'hFF;
    end

    // One-hot select for the scanned digit.
    always_comb begin
        select            = '0;
        select[scanIndex] = 1'b1;
    end

    // Segments and digit select registered together to avoid ghosting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segmentEnableN <= 8'hFF;
            digitEnableN   <= '1;
        end else begin
            segmentEnableN <= pattern;
            digitEnableN   <= ~select;
        end
    end

endmodule
